meta_info_streamer: RTL and testbench
=====================================

// Module: meta_info_streamer
// PURPOSE
//  Sequencer for the project meta-info string ROM ({proj_idx, chr_idx} -> chr).
//  Given a project index, walks chr_idx from 0 and waits out the ROM read latency.
//  Emits each character on a valid/ready byte stream. Stops at NUL or MAX_LEN chars.
//  Sits between the meta-info ROM and a byte consumer (UART TX, debug port).
// PARAMETERS
//  IDX_W    6   width of proj_idx and chr_idx
//  CHR_W    8   character width
//  ROM_LAT  2   cycles from a stable ROM address to valid rom_chr (>=1)
//  MAX_LEN  63  max chars per string; indices 0..MAX_LEN-1 (<= 2**IDX_W-1)
// PORTS
//  clock         in   1      single clock, rising edge
//  reset         in   1      asynchronous, active-high
//  start         in   1      begin streaming; sampled in IDLE only
//  proj_sel      in   IDX_W  project index, latched on accepted start
//  abort         in   1      cancel the stream in progress
//  rom_proj_idx  out  IDX_W  ROM project address (latched proj_sel)
//  rom_chr_idx   out  IDX_W  ROM character address
//  rom_chr       in   CHR_W  ROM data, valid ROM_LAT cycles after the address
//  out_data      out  CHR_W  stream byte
//  out_valid     out  1      stream valid
//  out_ready     in   1      consumer ready; transfer = valid & ready at an edge
//  busy          out  1      high in any state other than IDLE
//  done          out  1      one-cycle pulse: string finished normally
//  len           out  IDX_W  chars transferred in the last completed string
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all outputs 0 (rom_*, out_data, len too).
//  States: IDLE, FETCH, EMIT, DONE.
//  IDLE: start=1 -> latch proj_sel, rom_chr_idx=0, wait_cnt=0, char_cnt=0 -> FETCH.
//  FETCH: address held. wait_cnt increments each cycle.
//   - At the edge where wait_cnt==ROM_LAT-1, rom_chr is sampled.
//   - rom_chr==0 -> DONE. Else out_data=rom_chr, out_valid=1 -> EMIT.
//   - FETCH therefore lasts exactly ROM_LAT cycles.
//  EMIT: out_valid=1; out_data and rom_* held stable until the transfer.
//   - On transfer: char_cnt+1, out_valid=0.
//   - rom_chr_idx==MAX_LEN-1 -> DONE (index MAX_LEN is never addressed).
//   - Else rom_chr_idx+1, wait_cnt=0 -> FETCH.
//  DONE: done=1 and len=char_cnt for this one cycle -> IDLE.
//   - len holds its value until the next DONE or reset.
//  Timing, start sampled at edge E0 with ROM_LAT=2:
//   - First out_valid is visible after E2.
//   - With out_ready held high, one char every ROM_LAT+1 = 3 cycles.
//   - Empty string: done high in the cycle after E2.
//  start while busy: ignored, no queueing. proj_sel changes while busy: ignored.
//  abort=1 in FETCH, EMIT or DONE: -> IDLE at the next edge.
//   - out_valid drops (the only case valid falls without a transfer).
//   - No done pulse; len unchanged.
//   - abort and start together in IDLE: abort wins, stays IDLE.
//   - abort in DONE: done still pulses that cycle; len already written.
//  out_valid never asserts in IDLE, FETCH or DONE.
//  Counters: IDX_W bits, no wrap possible since MAX_LEN <= 2**IDX_W-1.
// TESTING
//  1 Reset mid-EMIT (ROM_LAT=2) -> next cycle IDLE, out_valid=0, busy=0, len=0, rom_chr_idx=0.
//  2 ROM proj 5 = "AB\0", out_ready=1, start@E0 -> 0x41 after E2, 0x42 after E5.
//    done pulse after E8, len=2, rom_proj_idx=5.
//  3 ROM proj 0 = "\0" -> no out_valid; done after E2; len=0; busy low after E3.
//  4 out_ready=0 for 5 cycles on the 1st char -> out_data, out_valid, rom_chr_idx stable.
//    Char 2 follows 3 cycles after ready rises.
//  5 63 non-NUL chars -> 63 transfers; rom_chr_idx peaks at 62; len=63; done once.
//  6 start while busy (new proj_sel) ignored.
//    abort in EMIT of char 3 -> IDLE next edge, no done, len keeps previous value.

Source files
------------

// File: rtl/meta_info_streamer.sv
// Walks one string of the meta-info ROM and emits its characters on a valid/ready byte
// stream, waiting out the ROM read latency before each character.
module meta_info_streamer #(
    parameter int IDX_W   = 6,
    parameter int CHR_W   = 8,
    parameter int ROM_LAT = 2,
    parameter int MAX_LEN = 63
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W-1:0] proj_sel,
    input  logic             abort,
    output logic [IDX_W-1:0] rom_proj_idx,
    output logic [IDX_W-1:0] rom_chr_idx,
    input  logic [CHR_W-1:0] rom_chr,
    output logic [CHR_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] len
);

    localparam int WAIT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ROM_LAT - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(MAX_LEN - 1);

    typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [IDX_W-1:0]  char_cnt;
    logic              fetch_last;
    logic              xfer;
    logic              last_chr;

    assign fetch_last = (state == FETCH) && (wait_cnt == WAIT_LAST);
    assign xfer       = (state == EMIT) && out_ready;
    assign last_chr   = (rom_chr_idx == LAST_IDX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort overrides every transition, including a start arriving in IDLE.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = FETCH;
                FETCH:   if (fetch_last) state_nxt = (rom_chr == '0) ? DONE : EMIT;
                EMIT:    if (out_ready) state_nxt = last_chr ? DONE : FETCH;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == DONE);
        out_valid = (state == EMIT);
    end

    // len is written on entry to DONE so it is already valid while done is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rom_proj_idx <= '0;
            rom_chr_idx  <= '0;
            out_data     <= '0;
            wait_cnt     <= '0;
            char_cnt     <= '0;
            len          <= '0;
        end else if (!abort) begin
            if (state == IDLE && start) begin
                rom_proj_idx <= proj_sel;
                rom_chr_idx  <= '0;
                wait_cnt     <= '0;
                char_cnt     <= '0;
            end
            if (state == FETCH) begin
                wait_cnt <= wait_cnt + 1'b1;
                if (fetch_last) begin
                    if (rom_chr != '0) begin
                        out_data <= rom_chr;
                    end else begin
                        len <= char_cnt;
                    end
                end
            end
            if (xfer) begin
                char_cnt <= char_cnt + 1'b1;
                if (last_chr) begin
                    len <= char_cnt + 1'b1;
                end else begin
                    rom_chr_idx <= rom_chr_idx + 1'b1;
                    wait_cnt    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_meta_info_streamer.sv
// Bench for meta_info_streamer: directed timing scenarios plus randomized strings and
// back-pressure checked against a string-level reference of the ROM contents.
module tb_meta_info_streamer;

    localparam int IDX_W   = 6;
    localparam int CHR_W   = 8;
    localparam int ROM_LAT = 2;
    localparam int MAX_LEN = 63;

    logic             clock;
    logic             reset;
    logic             start;
    logic [IDX_W-1:0] proj_sel;
    logic             abort;
    logic [IDX_W-1:0] rom_proj_idx;
    logic [IDX_W-1:0] rom_chr_idx;
    logic [CHR_W-1:0] rom_chr;
    logic [CHR_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] len;

    int errors = 0;
    int checks = 0;

    logic [CHR_W-1:0] mem [0:63][0:63];
    logic [CHR_W-1:0] rom_q;

    meta_info_streamer #(
        .IDX_W(IDX_W), .CHR_W(CHR_W), .ROM_LAT(ROM_LAT), .MAX_LEN(MAX_LEN)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .proj_sel(proj_sel), .abort(abort),
        .rom_proj_idx(rom_proj_idx), .rom_chr_idx(rom_chr_idx), .rom_chr(rom_chr),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .len(len)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM with a two-cycle read latency: one register after the address.
    always @(posedge clock) rom_q <= mem[rom_proj_idx][rom_chr_idx];
    assign rom_chr = rom_q;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference: length of the string for a project (stops at NUL or MAX_LEN chars).
    function automatic int ref_len(input int p);
        for (int i = 0; i < MAX_LEN; i++) if (mem[p][i] == 0) return i;
        return MAX_LEN;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_valid_done got=%b%b exp=00", out_valid, done); end
        checks++; if (len !== 0 || rom_chr_idx !== 0 || rom_proj_idx !== 0 || out_data !== 0) begin
            errors++; $display("FAIL reset_regs len=%0d chr_idx=%0d proj=%0d data=%h exp all 0", len, rom_chr_idx, rom_proj_idx, out_data);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic exp_v;
        mem[5][0] = 8'h41; mem[5][1] = 8'h42; mem[5][2] = 8'h00;
        out_ready = 1'b1; proj_sel = 6'd5; start = 1'b1;
        step();
        start = 1'b0; proj_sel = 6'd0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
        for (int e = 1; e <= 9; e++) begin
            step();
            exp_v = (e == 2 || e == 5);
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL basic_valid E%0d got=%b exp=%b", e, out_valid, exp_v); end
            checks++; if (done !== (e == 8)) begin errors++; $display("FAIL basic_done E%0d got=%b exp=%b", e, done, e == 8); end
            if (e == 2) begin
                checks++; if (out_data !== 8'h41) begin errors++; $display("FAIL basic_char0 got=%h exp=41", out_data); end
            end
            if (e == 5) begin
                checks++; if (out_data !== 8'h42) begin errors++; $display("FAIL basic_char1 got=%h exp=42", out_data); end
            end
            if (e == 8) begin
                checks++; if (len !== 2) begin errors++; $display("FAIL basic_len got=%0d exp=2", len); end
                checks++; if (rom_proj_idx !== 5) begin errors++; $display("FAIL basic_proj got=%0d exp=5", rom_proj_idx); end
            end
            if (e == 9) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle got=%b exp=0", busy); end
            end
        end
    endtask

    task automatic test_reset_mid_emit();
        out_ready = 1'b1; proj_sel = 6'd5; start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 5; e++) step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || rom_chr_idx !== 1) begin
            errors++; $display("FAIL rstmid_pre valid=%b idx=%0d exp valid=1 idx=1", out_valid, rom_chr_idx);
        end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state valid=%b busy=%b exp 0 0", out_valid, busy); end
        checks++; if (len !== 0 || rom_chr_idx !== 0) begin errors++; $display("FAIL rstmid_regs len=%0d idx=%0d exp 0 0", len, rom_chr_idx); end
        step();
        reset = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle busy=%b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        int waited;
        out_ready = 1'b0; proj_sel = 6'd5; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        for (int c = 0; c < 5; c++) begin
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h41 || rom_chr_idx !== 0) begin
                errors++; $display("FAIL bp_hold cyc=%0d valid=%b data=%h idx=%0d exp 1 41 0", c, out_valid, out_data, rom_chr_idx);
            end
        end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_after_xfer valid=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_fetch valid=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h42) begin errors++; $display("FAIL bp_char1 valid=%b data=%h exp 1 42", out_valid, out_data); end
        waited = 0;
        while (!done && waited < 10) begin step(); waited++; end
        checks++; if (!done || len !== 2) begin errors++; $display("FAIL bp_done done=%b len=%0d exp 1 2", done, len); end
        step();
    endtask

    task automatic test_empty();
        mem[0][0] = 8'h00;
        out_ready = 1'b1; proj_sel = 6'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_valid E%0d got=%b exp=0", e, out_valid); end
            checks++; if (done !== (e == 2)) begin errors++; $display("FAIL empty_done E%0d got=%b exp=%b", e, done, e == 2); end
            checks++; if (busy !== (e <= 2)) begin errors++; $display("FAIL empty_busy E%0d got=%b exp=%b", e, busy, e <= 2); end
            if (e == 2) begin
                checks++; if (len !== 0) begin errors++; $display("FAIL empty_len got=%0d exp=0", len); end
            end
        end
    endtask

    task automatic test_max_len();
        int k = 0;
        int ndone = 0;
        int maxidx = 0;
        int cyc = 0;
        for (int i = 0; i < 64; i++) mem[10][i] = 8'($urandom_range(1, 255));
        out_ready = 1'b1; proj_sel = 6'd10; start = 1'b1;
        step();
        start = 1'b0;
        while (busy && cyc < 400) begin
            if (out_valid && out_ready) begin
                checks++; if (out_data !== mem[10][k]) begin errors++; $display("FAIL max_char%0d got=%h exp=%h", k, out_data, mem[10][k]); end
                k++;
            end
            if (int'(rom_chr_idx) > maxidx) maxidx = int'(rom_chr_idx);
            step();
            cyc++;
            if (done) begin
                ndone++;
                checks++; if (len !== 63) begin errors++; $display("FAIL max_len got=%0d exp=63", len); end
            end
        end
        checks++; if (cyc >= 400) begin errors++; $display("FAIL max_timeout cycles=%0d limit=400", cyc); end
        checks++; if (k !== ref_len(10)) begin errors++; $display("FAIL max_count got=%0d exp=%0d", k, ref_len(10)); end
        checks++; if (maxidx !== MAX_LEN - 1) begin errors++; $display("FAIL max_peak_idx got=%0d exp=%0d", maxidx, MAX_LEN - 1); end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL max_done_count got=%0d exp=1", ndone); end
    endtask

    task automatic test_busy_abort();
        int k = 0;
        int cyc = 0;
        out_ready = 1'b1; proj_sel = 6'd10; start = 1'b1;
        step();
        proj_sel = 6'd5;
        while (!(out_valid && k == 2) && cyc < 50) begin
            if (out_valid && out_ready) k++;
            step();
            cyc++;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL busy_spurious_done cyc=%0d", cyc); end
        end
        checks++; if (cyc >= 50) begin errors++; $display("FAIL busy_timeout cycles=%0d limit=50", cyc); end
        checks++; if (rom_proj_idx !== 10 || out_data !== mem[10][2]) begin
            errors++; $display("FAIL busy_ignored proj=%0d data=%h exp 10 %h", rom_proj_idx, out_data, mem[10][2]);
        end
        abort = 1'b1;
        step();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_state busy=%b valid=%b done=%b exp 000", busy, out_valid, done);
        end
        checks++; if (len !== 63) begin errors++; $display("FAIL abort_len got=%0d exp=63", len); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_idle busy=%b exp=0", busy); end
        abort = 1'b0; start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if (done !== 1'b0 || busy !== 1'b0 || len !== 63) begin
                errors++; $display("FAIL abort_after done=%b busy=%b len=%0d exp 0 0 63", done, busy, len);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int p;
            int n;
            int exp_len;
            int k = 0;
            int cyc = 0;
            bit seen_done = 0;
            logic v;
            logic r;
            logic [CHR_W-1:0] d;
            p = $urandom_range(1, 63);
            n = (it == 9) ? 63 : $urandom_range(0, 12);
            for (int i = 0; i < 64; i++) mem[p][i] = 8'($urandom_range(1, 255));
            if (n < 63) mem[p][n] = 8'h00;
            exp_len = ref_len(p);
            proj_sel = 6'(p); start = 1'b1; out_ready = 1'($urandom_range(0, 1));
            step();
            start = 1'b0;
            while (!(seen_done && !busy) && cyc < 1500) begin
                out_ready = 1'($urandom_range(0, 1));
                proj_sel = 6'($urandom_range(0, 63));
                v = out_valid; r = out_ready; d = out_data;
                if (v && r) begin
                    checks++; if (k >= exp_len || d !== mem[p][k]) begin
                        errors++; $display("FAIL rnd_char it=%0d k=%0d got=%h exp=%h", it, k, d, mem[p][k]);
                    end
                    k++;
                end
                step();
                cyc++;
                if (v && !r) begin
                    checks++; if (out_valid !== 1'b1 || out_data !== d) begin
                        errors++; $display("FAIL rnd_hold it=%0d valid=%b data=%h exp 1 %h", it, out_valid, out_data, d);
                    end
                end
                if (done) begin
                    seen_done = 1;
                    checks++; if (len !== exp_len || k !== exp_len || rom_proj_idx !== p) begin
                        errors++; $display("FAIL rnd_done it=%0d len=%0d xfers=%0d proj=%0d exp %0d %0d %0d", it, len, k, rom_proj_idx, exp_len, exp_len, p);
                    end
                end
            end
            checks++; if (!seen_done || cyc >= 1500) begin errors++; $display("FAIL rnd_timeout it=%0d cycles=%0d done_seen=%0d", it, cyc, seen_done); end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; proj_sel = '0;
        for (int p = 0; p < 64; p++)
            for (int i = 0; i < 64; i++) mem[p][i] = 8'($urandom_range(1, 255));
        test_reset();
        test_basic();
        test_reset_mid_emit();
        test_backpressure();
        test_empty();
        test_max_len();
        test_busy_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
